// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encodings and sizing for the TDM demultiplexer.
package tdm_pkg;
   localparam int TDM_W     = 2;
   localparam int NUM_SLOTS = 3;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      EXP_V = 2'b01,
      EXP_W = 2'b10
   } state_e;
endpackage

// File: rtl/tdm_slot_reg.sv
// tdm_slot_reg: W-bit holding register with load enable and a registered one-cycle update pulse.
module tdm_slot_reg #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         upd
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q   <= '0;
         upd <= 1'b0;
      end else begin
         if (ld) q <= d;
         upd <= ld;
      end
endmodule

// File: rtl/tdm_demux3.sv
// tdm_demux3: TDM receive demultiplexer routing frame words 0/1/2 into U/V/Wo.
// Defining TDM_PARITY_EN adds an even-parity check on D (DPar in, ParErr out).
module tdm_demux3 import tdm_pkg::*; #(
   parameter int W = TDM_W
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic [W-1:0] D,
   input  logic         Valid,
   input  logic         Frame,
`ifdef TDM_PARITY_EN
   input  logic         DPar,
   output logic         ParErr,
`endif
   output logic [W-1:0] U,
   output logic [W-1:0] V,
   output logic [W-1:0] Wo,
   output logic         UpdU,
   output logic         UpdV,
   output logic         UpdW,
   output logic         FrameDone,
   output logic         SyncErr,
   output logic [1:0]   Slot
);
   state_e               state, nxt;
   logic [NUM_SLOTS-1:0] ld, upd;
   logic [W-1:0]         q [NUM_SLOTS];
   logic                 sync_err, par_err;
`ifdef TDM_PARITY_EN
   assign par_err = Valid && (DPar != ^D);
`else
   assign par_err = 1'b0;
`endif
   // A parity failure outranks every framing rule and drops the frame.
   always_comb begin
      nxt      = state;
      ld       = '0;
      sync_err = 1'b0;
      if (!(state inside {IDLE, EXP_V, EXP_W})) nxt = IDLE;
      else if (par_err) nxt = IDLE;
      else if (Valid)
         case (state)
            IDLE: begin
               ld[0]    = Frame;
               sync_err = !Frame;
               nxt      = Frame ? EXP_V : IDLE;
            end
            EXP_V: begin
               ld[0]    = Frame;
               ld[1]    = !Frame;
               sync_err = Frame;
               nxt      = Frame ? EXP_V : EXP_W;
            end
            EXP_W: begin
               ld[0]    = Frame;
               ld[2]    = !Frame;
               sync_err = Frame;
               nxt      = Frame ? EXP_V : IDLE;
            end
            default: nxt = IDLE;
         endcase
   end
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) begin
         state   <= IDLE;
         SyncErr <= 1'b0;
      end else begin
         state   <= nxt;
         SyncErr <= sync_err;
      end
`ifdef TDM_PARITY_EN
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) ParErr <= 1'b0;
      else ParErr <= par_err;
`endif
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      tdm_slot_reg #(.W(W)) u_reg (
         .clk   (Clock),
         .rst_n (Resetn),
         .ld    (ld[i]),
         .d     (D),
         .q     (q[i]),
         .upd   (upd[i])
      );
   end
   assign U         = q[0];
   assign V         = q[1];
   assign Wo        = q[2];
   assign UpdU      = upd[0];
   assign UpdV      = upd[1];
   assign UpdW      = upd[2];
   assign FrameDone = upd[2];
   assign Slot      = state;
endmodule

// File: tb/tb_tdm_demux3.sv
// tb_tdm_demux3: directed self-checking bench for tdm_demux3 (parity cases under TDM_PARITY_EN).
module tb_tdm_demux3;
   logic       Clock = 1'b0;
   logic       Resetn = 1'b0;
   logic [1:0] D = '0;
   logic       Valid = 1'b0;
   logic       Frame = 1'b0;
   logic [1:0] U, V, Wo, Slot;
   logic       UpdU, UpdV, UpdW, FrameDone, SyncErr;
   int         n_chk = 0;
   int         n_fail = 0;
`ifdef TDM_PARITY_EN
   logic       DPar = 1'b0;
   logic       ParErr;
   logic       bad_par = 1'b0;
`endif
   always #5 Clock = ~Clock;
   tdm_demux3 #(.W(2)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .D         (D),
      .Valid     (Valid),
      .Frame     (Frame),
`ifdef TDM_PARITY_EN
      .DPar      (DPar),
      .ParErr    (ParErr),
`endif
      .U         (U),
      .V         (V),
      .Wo        (Wo),
      .UpdU      (UpdU),
      .UpdV      (UpdV),
      .UpdW      (UpdW),
      .FrameDone (FrameDone),
      .SyncErr   (SyncErr),
      .Slot      (Slot)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Outputs packed as {U,V,Wo} and {UpdU,UpdV,UpdW,FrameDone,SyncErr}.
   task automatic chk_all(input string tag, input logic [5:0] uvw, input logic [4:0] p, input logic [1:0] s);
      chk({tag, ".uvw"}, {2'b00, U, V, Wo}, {2'b00, uvw});
      chk({tag, ".pulses"}, {3'b000, UpdU, UpdV, UpdW, FrameDone, SyncErr}, {3'b000, p});
      chk({tag, ".slot"}, {6'b0, Slot}, {6'b0, s});
   endtask
   task automatic step(input logic v, input logic f, input logic [1:0] d);
      @(negedge Clock);
      Valid = v;
      Frame = f;
      D     = d;
`ifdef TDM_PARITY_EN
      DPar  = (^d) ^ bad_par;
`endif
      @(posedge Clock);
      #1;
   endtask
   initial begin
      #3;
      chk_all("reset", 6'b00_00_00, 5'b00000, 2'b00);
      @(negedge Clock);
      Resetn = 1'b1;
      // Scenario 1: basic frame
      step(1, 1, 2'b01); chk_all("s1.u", 6'b01_00_00, 5'b10000, 2'b01);
      step(1, 0, 2'b10); chk_all("s1.v", 6'b01_10_00, 5'b01000, 2'b10);
      step(1, 0, 2'b11); chk_all("s1.w", 6'b01_10_11, 5'b00110, 2'b00);
      step(0, 0, 2'b00); chk_all("s1.idle", 6'b01_10_11, 5'b00000, 2'b00);
      // Scenario 2: unframed word in IDLE
      step(1, 0, 2'b00); chk_all("s2.err", 6'b01_10_11, 5'b00001, 2'b00);
      step(0, 0, 2'b00); chk_all("s2.clr", 6'b01_10_11, 5'b00000, 2'b00);
      // Scenario 3: resync while in EXP_W
      step(1, 1, 2'b01); chk_all("s3.u", 6'b01_10_11, 5'b10000, 2'b01);
      step(1, 0, 2'b10); chk_all("s3.v", 6'b01_10_11, 5'b01000, 2'b10);
      step(1, 1, 2'b00); chk_all("s3.resync", 6'b00_10_11, 5'b10001, 2'b01);
      step(1, 1, 2'b11); chk_all("s3.resync_v", 6'b11_10_11, 5'b10001, 2'b01);
      step(1, 0, 2'b01); chk_all("s3.v2", 6'b11_01_11, 5'b01000, 2'b10);
      step(1, 0, 2'b10); chk_all("s3.w2", 6'b11_01_10, 5'b00110, 2'b00);
      // Scenario 4: stalls between words
      step(1, 1, 2'b10); chk_all("s4.u", 6'b10_01_10, 5'b10000, 2'b01);
      for (int i = 0; i < 5; i++) begin step(0, 1, 2'b11); chk_all("s4.gap1", 6'b10_01_10, 5'b00000, 2'b01); end
      step(1, 0, 2'b01); chk_all("s4.v", 6'b10_01_10, 5'b01000, 2'b10);
      for (int i = 0; i < 5; i++) begin step(0, 0, 2'b00); chk_all("s4.gap2", 6'b10_01_10, 5'b00000, 2'b10); end
      step(1, 0, 2'b11); chk_all("s4.w", 6'b10_01_11, 5'b00110, 2'b00);
      // Scenario 5: async reset mid-frame, then back-to-back frames
      step(1, 1, 2'b11); chk_all("s5.u", 6'b11_01_11, 5'b10000, 2'b01);
      @(negedge Clock);
      Valid = 1'b0;
      #2 Resetn = 1'b0;
      #1 chk_all("s5.async", 6'b00_00_00, 5'b00000, 2'b00);
      @(negedge Clock);
      Resetn = 1'b1;
      step(1, 1, 2'b11); chk_all("s5.f1u", 6'b11_00_00, 5'b10000, 2'b01);
      step(1, 0, 2'b11); chk_all("s5.f1v", 6'b11_11_00, 5'b01000, 2'b10);
      step(1, 0, 2'b11); chk_all("s5.f1w", 6'b11_11_11, 5'b00110, 2'b00);
      step(1, 1, 2'b10); chk_all("s5.f2u", 6'b10_11_11, 5'b10000, 2'b01);
      step(1, 0, 2'b01); chk_all("s5.f2v", 6'b10_01_11, 5'b01000, 2'b10);
      step(1, 0, 2'b00); chk_all("s5.f2w", 6'b10_01_00, 5'b00110, 2'b00);
`ifdef TDM_PARITY_EN
      // Scenario 6: parity mismatch in IDLE and mid-frame
      bad_par = 1'b1;
      step(1, 1, 2'b01); chk_all("s6.idle", 6'b10_01_00, 5'b00000, 2'b00);
      chk("s6.parerr", {7'b0, ParErr}, 8'd1);
      bad_par = 1'b0;
      step(1, 1, 2'b11); chk_all("s6.u", 6'b11_01_00, 5'b10000, 2'b01);
      chk("s6.parok", {7'b0, ParErr}, 8'd0);
      bad_par = 1'b1;
      step(1, 1, 2'b10); chk_all("s6.mid", 6'b11_01_00, 5'b00000, 2'b00);
      chk("s6.parerr2", {7'b0, ParErr}, 8'd1);
      bad_par = 1'b0;
      step(0, 0, 2'b00);
      chk("s6.clr", {7'b0, ParErr}, 8'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
